// File: rtl/ternary_sign_select_pipe_pkg.sv
// Shared definitions for the ternary sign-select datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   tern_code_t      2-bit ternary weight code
//   TERN_ZERO/POS/NEG/RSVD  code encodings
//   tern_beats()     beats per vector (VEC_LEN / LANES)
//   tern_idx_w()     width of the beat index, never below 1 bit
package tern_pkg;

  typedef logic [1:0] tern_code_t;

  // Encodings match the legacy stage: bit 0 marks "non-zero", bit 1 marks
  // "negative". 2'b10 (negative zero) has no meaning and is flagged.
  localparam tern_code_t TERN_ZERO = 2'b00;
  localparam tern_code_t TERN_POS  = 2'b01;
  localparam tern_code_t TERN_NEG  = 2'b11;
  localparam tern_code_t TERN_RSVD = 2'b10;

  // Number of LANES-wide beats making up one vector.
  function automatic int tern_beats(input int vec_len, input int lanes);
    return vec_len / lanes;
  endfunction

  // Beat index width. A single-beat vector still gets a 1-bit index so the
  // port never collapses to zero width.
  function automatic int tern_idx_w(input int vec_len, input int lanes);
    int beats;
    beats = vec_len / lanes;
    if (beats <= 1) begin
      return 1;
    end
    return $clog2(beats);
  endfunction

endpackage : tern_pkg

// File: rtl/ternary_sign_select_pipe_lane_sel.sv
// One ternary lane: product = a * w for w in {-1, 0, +1}, plus flags.
// Latency: combinational (0 cycles).
// Backpressure: none; the enclosing pipe register handles flow control.
//
// Ports:
//   a        signed activation, DATA_W bits
//   wcode    ternary weight code (see tern_pkg)
//   product  signed result, DATA_W bits
//   nz       code is +1 or -1 (counted toward the beat's non-zero total)
//   rsvd     code is the reserved encoding 2'b10
//
// Build option: TERN_SAT_EN defined makes -(-2^(DATA_W-1)) saturate to
// +2^(DATA_W-1)-1; undefined keeps plain two's-complement wrap, which is
// bit-identical to the legacy per-element stage.
module tern_lane_sel
  import tern_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic signed [DATA_W-1:0] a,
  input  tern_code_t               wcode,
  output logic signed [DATA_W-1:0] product,
  output logic                     nz,
  output logic                     rsvd
);

  // Most negative and most positive representable values.
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};

  logic signed [DATA_W-1:0] neg_wrap;
  logic signed [DATA_W-1:0] neg_a;

  // Negation at DATA_W bits: the only overflowing input is MIN_VAL, whose
  // wrapped negation is itself.
  assign neg_wrap = -a;

`ifdef TERN_SAT_EN
  assign neg_a = (a == MIN_VAL) ? MAX_VAL : neg_wrap;
`else
  assign neg_a = neg_wrap;
`endif

  always_comb begin
    product = '0;
    nz      = 1'b0;
    rsvd    = 1'b0;
    case (wcode)
      TERN_POS: begin
        product = a;
        nz      = 1'b1;
      end
      TERN_NEG: begin
        product = neg_a;
        nz      = 1'b1;
      end
      TERN_RSVD: begin
        // Reserved code behaves as zero but is reported upstream.
        rsvd = 1'b1;
      end
      default: begin
        // TERN_ZERO: product stays 0, not counted.
      end
    endcase
  end

endmodule : tern_lane_sel

// File: rtl/ternary_sign_select_pipe.sv
// Streaming ternary sign-select: LANES products a*w per beat, registered.
// Latency: 1 cycle from accept edge to out_valid with data.
// Backpressure: single skid-free stage; in_ready = !out_valid || out_ready,
//               so a new beat loads in the same cycle the held one drains.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  input handshake
//   in_data         LANES x DATA_W signed activations, lane i at [i]
//   in_wcode        LANES x 2 ternary weight codes, lane i at [i]
//   out_valid/ready output handshake
//   out_data        LANES x DATA_W signed products
//   out_last        beat is the final one (index BEATS-1) of the vector
//   out_beat_idx    beat position within the vector
//   out_nz_cnt      lanes whose code was +1 or -1
//   err_code        sticky: a reserved code was accepted since reset
//
// Build option: TERN_SAT_EN (see tern_lane_sel) selects saturating negation.
module ternary_sign_select_pipe
  import tern_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int LANES   = 64,
  parameter  int VEC_LEN = 4096,
  localparam int BEATS   = tern_beats(VEC_LEN, LANES),
  localparam int IDX_W   = tern_idx_w(VEC_LEN, LANES),
  localparam int CNT_W   = $clog2(LANES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic [LANES*2-1:0]        in_wcode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic                      out_last,
  output logic [IDX_W-1:0]          out_beat_idx,
  output logic [CNT_W-1:0]          out_nz_cnt,
  output logic                      err_code
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  logic [LANES*DATA_W-1:0] lane_prod;
  logic [LANES-1:0]        lane_nz;
  logic [LANES-1:0]        lane_rsvd;
  logic [CNT_W-1:0]        nz_sum;
  logic                    any_rsvd;
  logic                    accept;
  logic [IDX_W-1:0]        beat_cnt;

  // ------------------------------------------------------------------
  // Per-lane product and flags
  // ------------------------------------------------------------------
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    tern_lane_sel #(
      .DATA_W (DATA_W)
    ) u_lane (
      .a       (in_data[i*DATA_W +: DATA_W]),
      .wcode   (in_wcode[i*2 +: 2]),
      .product (lane_prod[i*DATA_W +: DATA_W]),
      .nz      (lane_nz[i]),
      .rsvd    (lane_rsvd[i])
    );
  end

  // Population count of non-zero lanes for the statistics field.
  always_comb begin
    nz_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      nz_sum = nz_sum + CNT_W'(lane_nz[i]);
    end
  end

  assign any_rsvd = |lane_rsvd;

  // ------------------------------------------------------------------
  // Handshake
  // ------------------------------------------------------------------
  // The register is free when empty or when its beat leaves this cycle.
  // in_valid deliberately does not feed in_ready.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // ------------------------------------------------------------------
  // Beat position counter: wraps after the last beat so vectors stream
  // back-to-back without a bubble.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (accept) begin
      if (beat_cnt == LAST_IDX) begin
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Output register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      out_beat_idx <= '0;
      out_nz_cnt   <= '0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_data     <= lane_prod;
      out_last     <= (beat_cnt == LAST_IDX);
      out_beat_idx <= beat_cnt;
      out_nz_cnt   <= nz_sum;
    end else if (out_ready) begin
      // Drained with nothing behind it; payload is held but marked invalid.
      out_valid <= 1'b0;
    end
  end

  // Sticky error: only accepted beats can raise it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_code <= 1'b0;
    end else if (accept && any_rsvd) begin
      err_code <= 1'b1;
    end
  end

endmodule : ternary_sign_select_pipe

// File: tb/tb_ternary_sign_select_pipe.sv
module tb_ternary_sign_select_pipe;
  import tern_pkg::*;

  localparam int DW    = 8;
  localparam int LANES = 64;
  localparam int VLEN  = 256;
  localparam int NBEAT = VLEN / LANES;   // 4
  localparam int IW    = 2;
  localparam int CW    = 7;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   in_data;
  logic [LANES*2-1:0]    in_wcode;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*DW-1:0]   out_data;
  logic                  out_last;
  logic [IW-1:0]         out_beat_idx;
  logic [CW-1:0]         out_nz_cnt;
  logic                  err_code;

  ternary_sign_select_pipe #(.DATA_W(DW), .LANES(LANES), .VEC_LEN(VLEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_wcode(in_wcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .out_beat_idx(out_beat_idx), .out_nz_cnt(out_nz_cnt),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_idx = 0;

  typedef struct {
    logic [DW-1:0] a;
    logic [1:0]    code;
    logic [DW-1:0] exp;
    int            nz;
  } vec_t;

  typedef struct {
    logic [LANES*DW-1:0] data;
    int                  nz;
    int                  idx;
    logic                last;
  } beat_t;

  vec_t  tbl[10];
  beat_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [LANES*DW-1:0] act,
                      input logic [LANES*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Independent reference: integer arithmetic, then clamp or truncate.
  function automatic beat_t model(input logic [LANES*DW-1:0] d,
                                  input logic [LANES*2-1:0] w, input int idx);
    beat_t r;
    int a, p;
    r.data = '0;
    r.nz   = 0;
    for (int i = 0; i < LANES; i++) begin
      a = int'($signed(d[i*DW +: DW]));
      p = 0;
      if (w[i*2 +: 2] == 2'b01) begin p = a;  r.nz++; end
      if (w[i*2 +: 2] == 2'b11) begin p = -a; r.nz++; end
`ifdef TERN_SAT_EN
      if (p > 127) p = 127;
`endif
      r.data[i*DW +: DW] = p[DW-1:0];
    end
    r.idx  = idx;
    r.last = (idx == NBEAT - 1);
    return r;
  endfunction

  // Called at posedge+1; leaves inputs idle and time at the next posedge+1.
  task automatic send_beat(input logic [LANES*DW-1:0] d, input logic [LANES*2-1:0] w);
    in_data  = d;
    in_wcode = w;
    in_valid = 1'b1;
    #1;
    chk("in_ready_before_accept", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_idx  = (exp_idx + 1) % NBEAT;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst      = 1'b0;
    exp_idx  = 0;
  endtask

  initial begin
    logic [LANES*DW-1:0] d, exp_d, held;
    logic [LANES*2-1:0]  w;
    logic [DW-1:0]       sat_exp;
    beat_t               e;
    bit                  mv, acc;
    int                  accepted, cyc;

`ifdef TERN_SAT_EN
    sat_exp = 8'h7F;
`else
    sat_exp = 8'h80;
`endif
    //          a       code      expected  nz
    tbl[0] = '{8'd5,   TERN_POS,  8'd5,    64};
    tbl[1] = '{8'd5,   TERN_NEG,  8'hFB,   64};
    tbl[2] = '{8'd5,   TERN_ZERO, 8'd0,    0};
    tbl[3] = '{8'd5,   TERN_RSVD, 8'd0,    0};
    tbl[4] = '{8'h80,  TERN_NEG,  sat_exp, 64};
    tbl[5] = '{8'h7F,  TERN_NEG,  8'h81,   64};
    tbl[6] = '{8'h80,  TERN_POS,  8'h80,   64};
    tbl[7] = '{8'd0,   TERN_NEG,  8'd0,    64};
    tbl[8] = '{8'hFF,  TERN_NEG,  8'd1,    64};
    tbl[9] = '{8'hF9,  TERN_ZERO, 8'd0,    0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_wcode = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chkv("rst_out_data", out_data, '0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_beat_idx", out_beat_idx, 0);
    chk("rst_nz_cnt", out_nz_cnt, 0);
    chk("rst_err_code", err_code, 1'b0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1'b1);

    // Mixed beat: lanes 0..3 = {+1,-1,0,rsvd} on data 5, rest code 0.
    d = {LANES{8'd5}};
    w = '0;
    w[7:0] = 8'b10_00_11_01;
    exp_d = '0;
    exp_d[15:0] = 16'hFB05;
    chk("err_before_accept", err_code, 1'b0);
    send_beat(d, w);
    chk("mixed_valid", out_valid, 1'b1);
    chkv("mixed_data", out_data, exp_d);
    chk("mixed_nz", out_nz_cnt, 2);
    chk("mixed_idx", out_beat_idx, 0);
    chk("mixed_err", err_code, 1'b1);

    // Table: each record replicated across all lanes.
    for (int k = 0; k < 10; k++) begin
      int idx_now;
      idx_now = exp_idx;
      send_beat({LANES{tbl[k].a}}, {LANES{tbl[k].code}});
      chkv($sformatf("tbl%0d_data", k), out_data, {LANES{tbl[k].exp}});
      chk($sformatf("tbl%0d_nz", k), out_nz_cnt, tbl[k].nz);
      chk($sformatf("tbl%0d_idx", k), out_beat_idx, idx_now);
      chk($sformatf("tbl%0d_last", k), out_last, idx_now == NBEAT - 1);
    end

    // Back-to-back stream of two vectors.
    do_reset();
    for (int b = 0; b < 8; b++) begin
      in_data  = {LANES{8'(b + 1)}};
      in_wcode = {LANES{TERN_POS}};
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("strm%0d_valid", b), out_valid, 1'b1);
      chk($sformatf("strm%0d_idx", b), out_beat_idx, b % 4);
      chk($sformatf("strm%0d_last", b), out_last, (b % 4) == 3);
      chk($sformatf("strm%0d_lane0", b), out_data[7:0], b + 1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("strm_drain_valid", out_valid, 1'b0);

    // Backpressure: hold one beat for 3 cycles, next beat queued behind.
    out_ready = 1'b0;
    send_beat({LANES{8'd9}}, {LANES{TERN_NEG}});
    held = out_data;
    chkv("bp_first_data", held, {LANES{8'hF7}});
    in_data  = {LANES{8'd3}};
    in_wcode = {LANES{TERN_POS}};
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", c), in_ready, 1'b0);
      chk($sformatf("bp%0d_valid", c), out_valid, 1'b1);
      chkv($sformatf("bp%0d_data", c), out_data, held);
      chk($sformatf("bp%0d_idx", c), out_beat_idx, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chkv("bp_next_data", out_data, {LANES{8'd3}});
    chk("bp_next_idx", out_beat_idx, 1);
    @(posedge clk); #1;

    // Mid-vector reset after beat 2.
    do_reset();
    for (int b = 0; b < 3; b++) send_beat({LANES{8'd1}}, {LANES{TERN_RSVD}});
    chk("mid_idx_before", out_beat_idx, 2);
    chk("mid_err_before", err_code, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_valid_async", out_valid, 1'b0);
    chk("mid_err_async", err_code, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_idx = 0;
    // Reserved codes on a non-accepted cycle must not set the error.
    in_wcode = {LANES{TERN_RSVD}};
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_rsvd_err", err_code, 1'b0);
    send_beat({LANES{8'd2}}, {LANES{TERN_POS}});
    chk("mid_after_idx", out_beat_idx, 0);
    chk("mid_after_data", out_data[7:0], 2);

    // Random stream with random backpressure against the model.
    do_reset();
    mv = 1'b0; accepted = 0; cyc = 0;
    while (accepted < 1000 && cyc < 5000) begin
      for (int i = 0; i < LANES; i++) begin
        d[i*DW +: DW] = 8'($urandom);
        w[i*2 +: 2]   = 2'($urandom_range(0, 3));
      end
      in_data   = d;
      in_wcode  = w;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      chk("rnd_in_ready", in_ready, !mv || out_ready);
      chk("rnd_out_valid", out_valid, mv);
      if (mv && out_ready) begin
        if (sb.size() == 0) begin
          chk("rnd_unexpected_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          chkv("rnd_data", out_data, e.data);
          chk("rnd_nz", out_nz_cnt, e.nz);
          chk("rnd_idx", out_beat_idx, e.idx);
          chk("rnd_last", out_last, e.last);
        end
      end
      acc = in_valid && (!mv || out_ready);
      if (acc) begin
        sb.push_back(model(d, w, exp_idx));
        exp_idx = (exp_idx + 1) % NBEAT;
        accepted++;
      end
      mv = acc ? 1'b1 : (out_ready ? 1'b0 : mv);
      @(posedge clk); #1;
      cyc++;
    end
    chk("rnd_accept_budget", accepted, 1000);
    // Drain the last beat.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    if (mv) begin
      if (sb.size() == 0) begin
        chk("rnd_unexpected_tail", 1, 0);
      end else begin
        e = sb.pop_front();
        chkv("rnd_tail_data", out_data, e.data);
        chk("rnd_tail_idx", out_beat_idx, e.idx);
      end
    end
    @(posedge clk); #1;
    chk("rnd_final_valid", out_valid, 1'b0);
    chk("rnd_queue_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ternary_sign_select_pipe
